// File: rtl/serial_comparator_ctrl_pkg.sv
// rtl/serial_comparator_ctrl_pkg.sv - shared state encodings and defaults for the serial comparator
package serial_comparator_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic smaller;
        logic equal;
        logic greater;
    } cmp_result_t;

    localparam cmp_result_t RESULT_CLEAR = '{smaller: 1'b0, equal: 1'b0, greater: 1'b0};

endpackage

// File: rtl/serial_comparator_ctrl_bit.sv
// rtl/serial_comparator_ctrl_bit.sv - comparator_1bit, the single-bit magnitude compare cell
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic lt,
    output logic eq,
    output logic gt
);

    assign lt = ~a & b;
    assign gt = a & ~b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - bit-serial MSB-first magnitude comparator controller
// Optional SERIAL_CMP_SIGNED_EN: two's-complement compare by inverting a sign-bit decision.
module serial_comparator_ctrl
    import serial_comparator_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             smaller,
    output logic             equal,
    output logic             greater,
    output logic [CNT_W-1:0] bits_scanned
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_result_t      res_q, res_d;

    logic cell_lt, cell_eq, cell_gt;
    logic bit_lt, bit_gt;

    comparator_1bit u_cell (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .lt (cell_lt),
        .eq (cell_eq),
        .gt (cell_gt)
    );

`ifdef SERIAL_CMP_SIGNED_EN
    // A sign-bit difference means the operand with the 1 is the negative one.
    logic at_sign;
    assign at_sign = (idx_q == IDX_MSB);
    assign bit_lt  = at_sign ? cell_gt : cell_lt;
    assign bit_gt  = at_sign ? cell_lt : cell_gt;
`else
    assign bit_lt = cell_lt;
    assign bit_gt = cell_gt;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MSB;
                    cnt_d   = '0;
                    res_d   = RESULT_CLEAR;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!cell_eq) begin
                    res_d.smaller = bit_lt;
                    res_d.greater = bit_gt;
                    state_d       = S_DONE;
                end else if (idx_q == '0) begin
                    res_d.equal = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            res_q   <= RESULT_CLEAR;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q == S_SCAN);
    assign done         = (state_q == S_DONE);
    assign smaller      = res_q.smaller;
    assign equal        = res_q.equal;
    assign greater      = res_q.greater;
    assign bits_scanned = cnt_q;

endmodule
